// File: rtl/dcache_meta_read_responder.sv
// Data-cache metadata read responder: owns the tag/coherence array and clears
// it after reset. It serves one arbitrated read per cycle through a 2-entry
// response FIFO and takes refill/probe writes with priority over reads.
module dcache_meta_read_responder #(
    parameter int N_SETS    = 64,
    parameter int N_WAYS    = 8,
    parameter int TAG_BITS  = 20,
    parameter int COH_BITS  = 2,
    parameter int IDX_LSB   = 6,
    parameter int ADDR_BITS = 12,
    localparam int IDX_W    = $clog2(N_SETS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         io_req_valid,
    output logic                         io_req_ready,
    input  logic [N_WAYS-1:0]            io_req_bits_way_en,
    input  logic [ADDR_BITS-1:0]         io_req_bits_addr,
    input  logic                         io_req_bits_valid_0,
    input  logic [1:0]                   io_req_bits_src,
    input  logic                         io_write_valid,
    output logic                         io_write_ready,
    input  logic [IDX_W-1:0]             io_write_bits_idx,
    input  logic [N_WAYS-1:0]            io_write_bits_way_en,
    input  logic [TAG_BITS-1:0]          io_write_bits_tag,
    input  logic [COH_BITS-1:0]          io_write_bits_coh,
    output logic                         io_resp_valid,
    input  logic                         io_resp_ready,
    output logic [1:0]                   io_resp_bits_src,
    output logic [N_WAYS-1:0]            io_resp_bits_way_en,
    output logic [N_WAYS*TAG_BITS-1:0]   io_resp_bits_tag,
    output logic [N_WAYS*COH_BITS-1:0]   io_resp_bits_coh,
    output logic                         io_init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [IDX_W-1:0]           init_cnt_q;
    logic                       run;

    logic [TAG_BITS-1:0]        tag_mem [N_SETS][N_WAYS];
    logic [COH_BITS-1:0]        coh_mem [N_SETS][N_WAYS];

    logic [IDX_W-1:0]           rd_idx;
    logic [N_WAYS*TAG_BITS-1:0] rd_tag;
    logic [N_WAYS*COH_BITS-1:0] rd_coh;

    logic [1:0]                 fifo_src    [2];
    logic [N_WAYS-1:0]          fifo_way    [2];
    logic [N_WAYS*TAG_BITS-1:0] fifo_tag    [2];
    logic [N_WAYS*COH_BITS-1:0] fifo_coh    [2];
    logic                       wr_ptr_q;
    logic                       rd_ptr_q;
    logic [1:0]                 count_q;
    logic [1:0]                 count_d;

    logic [1:0]                 last_src_q;
    logic [N_WAYS-1:0]          last_way_q;
    logic [N_WAYS*TAG_BITS-1:0] last_tag_q;
    logic [N_WAYS*COH_BITS-1:0] last_coh_q;

    logic                       req_fire;
    logic                       enq;
    logic                       deq;
    logic                       unused_addr;

    assign run            = (state_q == ST_RUN);
    assign io_init_done   = run;
    assign io_write_ready = run;
    assign io_req_ready   = run & ~io_write_valid & (count_q < 2'd2);

    assign req_fire = io_req_valid & io_req_ready;
    assign enq      = req_fire & io_req_bits_valid_0;
    assign deq      = io_resp_valid & io_resp_ready;

    assign rd_idx      = io_req_bits_addr[IDX_LSB +: IDX_W];
    // Only the index field selects a set; the remaining address bits are ignored.
    assign unused_addr = ^io_req_bits_addr;

    // State register for the clear-sweep / run FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave INIT once the last set has been cleared; RUN is held until reset.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_cnt_q == IDX_W'(N_SETS - 1)) begin
            state_d = ST_RUN;
        end
    end

    // Set counter walking the array during the clear sweep.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + 1'b1;
        end
    end

    // Metadata storage write: clear sweep during INIT, refill/probe writes in RUN.
    always_ff @(posedge clock) begin
        if (!run) begin
            for (int unsigned w = 0; w < N_WAYS; w++) begin
                tag_mem[init_cnt_q][w] <= '0;
                coh_mem[init_cnt_q][w] <= '0;
            end
        end else if (io_write_valid) begin
            for (int unsigned w = 0; w < N_WAYS; w++) begin
                if (io_write_bits_way_en[w]) begin
                    tag_mem[io_write_bits_idx][w] <= io_write_bits_tag;
                    coh_mem[io_write_bits_idx][w] <= io_write_bits_coh;
                end
            end
        end
    end

    // Combinational set read with per-way masking by the request way_en.
    always_comb begin
        rd_tag = '0;
        rd_coh = '0;
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            if (io_req_bits_way_en[w]) begin
                rd_tag[w*TAG_BITS +: TAG_BITS] = tag_mem[rd_idx][w];
                rd_coh[w*COH_BITS +: COH_BITS] = coh_mem[rd_idx][w];
            end
        end
    end

    // Next FIFO occupancy; simultaneous enqueue and dequeue cancel out.
    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy; reset discards every queued response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (enq) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // FIFO payload storage, written at the tail on enqueue.
    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_src[wr_ptr_q] <= io_req_bits_src;
            fifo_way[wr_ptr_q] <= io_req_bits_way_en;
            fifo_tag[wr_ptr_q] <= rd_tag;
            fifo_coh[wr_ptr_q] <= rd_coh;
        end
    end

    // Copy of the last dequeued entry so the response bits hold it once empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_src_q <= '0;
            last_way_q <= '0;
            last_tag_q <= '0;
            last_coh_q <= '0;
        end else if (deq) begin
            last_src_q <= fifo_src[rd_ptr_q];
            last_way_q <= fifo_way[rd_ptr_q];
            last_tag_q <= fifo_tag[rd_ptr_q];
            last_coh_q <= fifo_coh[rd_ptr_q];
        end
    end

    // Head entry drives the response; new entries land at the tail so the
    // head stays stable while the consumer stalls.
    always_comb begin
        io_resp_valid       = (count_q != 2'd0);
        io_resp_bits_src    = last_src_q;
        io_resp_bits_way_en = last_way_q;
        io_resp_bits_tag    = last_tag_q;
        io_resp_bits_coh    = last_coh_q;
        if (count_q != 2'd0) begin
            io_resp_bits_src    = fifo_src[rd_ptr_q];
            io_resp_bits_way_en = fifo_way[rd_ptr_q];
            io_resp_bits_tag    = fifo_tag[rd_ptr_q];
            io_resp_bits_coh    = fifo_coh[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_dcache_meta_read_responder.sv
// Self-checking bench for dcache_meta_read_responder: a queue/array model
// predicts every output on each falling edge; directed cases pin literals.
module tb_dcache_meta_read_responder;

    localparam int NS = 64;
    localparam int NW = 8;
    localparam int TB = 20;
    localparam int CB = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [NW-1:0]     req_way = '0;
    logic [11:0]       req_addr = '0;
    logic              req_v0 = 1'b0;
    logic [1:0]        req_src = '0;
    logic              wv = 1'b0;
    logic              wready;
    logic [5:0]        w_idx = '0;
    logic [NW-1:0]     w_way = '0;
    logic [TB-1:0]     w_tag = '0;
    logic [CB-1:0]     w_coh = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [1:0]        resp_src;
    logic [NW-1:0]     resp_way;
    logic [NW*TB-1:0]  resp_tag;
    logic [NW*CB-1:0]  resp_coh;
    logic              init_done;

    dcache_meta_read_responder #(
        .N_SETS(NS), .N_WAYS(NW), .TAG_BITS(TB), .COH_BITS(CB),
        .IDX_LSB(6), .ADDR_BITS(12)
    ) dut (
        .clock(clock), .reset(reset),
        .io_req_valid(req_valid), .io_req_ready(req_ready),
        .io_req_bits_way_en(req_way), .io_req_bits_addr(req_addr),
        .io_req_bits_valid_0(req_v0), .io_req_bits_src(req_src),
        .io_write_valid(wv), .io_write_ready(wready),
        .io_write_bits_idx(w_idx), .io_write_bits_way_en(w_way),
        .io_write_bits_tag(w_tag), .io_write_bits_coh(w_coh),
        .io_resp_valid(resp_valid), .io_resp_ready(resp_ready),
        .io_resp_bits_src(resp_src), .io_resp_bits_way_en(resp_way),
        .io_resp_bits_tag(resp_tag), .io_resp_bits_coh(resp_coh),
        .io_init_done(init_done)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [1:0]       src;
        logic [NW-1:0]    way;
        logic [NW*TB-1:0] tag;
        logic [NW*CB-1:0] coh;
    } resp_t;

    logic [TB-1:0] m_tag [NS][NW];
    logic [CB-1:0] m_coh [NS][NW];
    resp_t         q[$];
    int            init_left = NS;

    // Inputs only change just after a rising edge, so at the falling edge they
    // describe exactly what the next rising edge will act on.
    always @(negedge clock) begin
        resp_t e;
        bit    exp_done, exp_rdy, do_deq, do_enq;
        int    idx;
        if (!reset) begin
            q.delete();
            init_left = NS;
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < NW; w++) begin
                    m_tag[s][w] = '0;
                    m_coh[s][w] = '0;
                end
            check("rst_resp_valid", 256'(resp_valid), 256'(0));
            check("rst_req_ready", 256'(req_ready), 256'(0));
            check("rst_init_done", 256'(init_done), 256'(0));
            check("rst_write_ready", 256'(wready), 256'(0));
            check("rst_resp_bits", 256'({resp_src, resp_way, resp_tag, resp_coh}), 256'(0));
        end else begin
            exp_done = (init_left == 0);
            exp_rdy  = exp_done && !wv && (q.size() < 2);
            check("init_done", 256'(init_done), 256'(exp_done));
            check("write_ready", 256'(wready), 256'(exp_done));
            check("req_ready", 256'(req_ready), 256'(exp_rdy));
            check("resp_valid", 256'(resp_valid), 256'(q.size() != 0));
            if (q.size() != 0) begin
                check("resp_src", 256'(resp_src), 256'(q[0].src));
                check("resp_way", 256'(resp_way), 256'(q[0].way));
                check("resp_tag", 256'(resp_tag), 256'(q[0].tag));
                check("resp_coh", 256'(resp_coh), 256'(q[0].coh));
            end
            do_deq = (q.size() != 0) && resp_ready;
            do_enq = req_valid && exp_rdy && req_v0;
            if (do_enq) begin
                idx = int'(req_addr) / 64;
                e.src = req_src;
                e.way = req_way;
                e.tag = '0;
                e.coh = '0;
                for (int w = 0; w < NW; w++)
                    if (req_way[w]) begin
                        e.tag[w*TB +: TB] = m_tag[idx][w];
                        e.coh[w*CB +: CB] = m_coh[idx][w];
                    end
            end
            if (do_deq) void'(q.pop_front());
            if (do_enq) q.push_back(e);
            if (exp_done && wv)
                for (int w = 0; w < NW; w++)
                    if (w_way[w]) begin
                        m_tag[w_idx][w] = w_tag;
                        m_coh[w_idx][w] = w_coh;
                    end
            if (init_left > 0) init_left--;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic measure_init(input string name);
        int n = 0;
        req_valid = 1'b1; req_v0 = 1'b1; req_way = '1; req_addr = 12'h040;
        while (!init_done && n < 200) begin
            @(posedge clock);
            n++;
            #1;
        end
        req_valid = 1'b0;
        check(name, 256'(n), 256'(NS));
    endtask

    task automatic do_req(input logic [NW-1:0] way, input logic [11:0] addr,
                          input logic v0, input logic [1:0] src);
        req_valid = 1'b1; req_way = way; req_addr = addr; req_v0 = v0; req_src = src;
        cyc(1);
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string name, input logic [1:0] src, input logic [NW-1:0] way,
                               input logic [NW*TB-1:0] tag, input logic [NW*CB-1:0] coh);
        @(negedge clock);
        check({name, "_valid"}, 256'(resp_valid), 256'(1));
        check({name, "_src"}, 256'(resp_src), 256'(src));
        check({name, "_way"}, 256'(resp_way), 256'(way));
        check({name, "_tag"}, 256'(resp_tag), 256'(tag));
        check({name, "_coh"}, 256'(resp_coh), 256'(coh));
        @(posedge clock);
        #1;
    endtask

    logic [NW*TB-1:0] etag;
    logic [NW*CB-1:0] ecoh;

    initial begin
        cyc(3);
        reset = 1'b1;
        measure_init("init_len");
        resp_ready = 1'b1;

        // Fresh array reads back all zero.
        do_req(8'hFF, 12'h27C, 1'b1, 2'd3);
        expect_resp("zero_read", 2'd3, 8'hFF, '0, '0);

        // Single-way write then full read of the same set.
        wv = 1'b1; w_idx = 6'd5; w_way = 8'h04; w_tag = 20'hABCDE; w_coh = 2'd2;
        cyc(1);
        wv = 1'b0;
        do_req(8'hFF, 12'h140, 1'b1, 2'd1);
        etag = '0; etag[40 +: 20] = 20'hABCDE;
        ecoh = '0; ecoh[4 +: 2] = 2'd2;
        expect_resp("wr_rd", 2'd1, 8'hFF, etag, ecoh);

        // Way masking hides way 2.
        do_req(8'h01, 12'h140, 1'b1, 2'd1);
        expect_resp("masked", 2'd1, 8'h01, '0, '0);

        // Back-pressure: three back-to-back requests with the consumer stalled.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_way = 8'hFF; req_addr = 12'h140; req_v0 = 1'b1; req_src = 2'd0;
        @(negedge clock); check("bp_rdy1", 256'(req_ready), 256'(1));
        @(posedge clock); #1; req_src = 2'd1;
        @(negedge clock); check("bp_rdy2", 256'(req_ready), 256'(1));
        @(posedge clock); #1; req_src = 2'd2;
        @(negedge clock); check("bp_rdy3", 256'(req_ready), 256'(0));
        check("bp_head0", 256'(resp_src), 256'(0));
        @(posedge clock); #1; resp_ready = 1'b1;
        @(negedge clock); check("bp_full_rdy", 256'(req_ready), 256'(0));
        check("bp_drain0", 256'(resp_src), 256'(0));
        @(posedge clock); #1;
        @(negedge clock); check("bp_rdy_again", 256'(req_ready), 256'(1));
        check("bp_drain1", 256'(resp_src), 256'(1));
        @(posedge clock); #1; req_valid = 1'b0;
        @(negedge clock); check("bp_drain2", 256'(resp_src), 256'(2));
        check("bp_drain2_tag", 256'(resp_tag[40 +: 20]), 256'(20'hABCDE));
        @(posedge clock); #1;
        @(negedge clock); check("bp_empty", 256'(resp_valid), 256'(0));
        @(posedge clock); #1;

        // Write and read together: write wins, read follows next cycle.
        wv = 1'b1; w_idx = 6'd7; w_way = 8'h80; w_tag = 20'h12345; w_coh = 2'd3;
        req_valid = 1'b1; req_way = 8'hFF; req_addr = 12'h1C0; req_v0 = 1'b1; req_src = 2'd3;
        @(negedge clock); check("wprio_blocked", 256'(req_ready), 256'(0));
        @(posedge clock); #1; wv = 1'b0;
        @(negedge clock); check("wprio_accept", 256'(req_ready), 256'(1));
        @(posedge clock); #1; req_valid = 1'b0;
        etag = '0; etag[140 +: 20] = 20'h12345;
        ecoh = '0; ecoh[14 +: 2] = 2'd3;
        expect_resp("wprio", 2'd3, 8'hFF, etag, ecoh);

        // Dummy request is consumed without a response.
        do_req(8'hFF, 12'h140, 1'b0, 2'd2);
        @(negedge clock); check("dummy_no_resp", 256'(resp_valid), 256'(0));
        @(posedge clock); #1;
        do_req(8'h80, 12'h1C0, 1'b1, 2'd0);
        etag = '0; etag[140 +: 20] = 20'h12345;
        ecoh = '0; ecoh[14 +: 2] = 2'd3;
        expect_resp("after_dummy", 2'd0, 8'h80, etag, ecoh);

        // Randomized traffic over a few sets so writes and reads collide.
        for (int i = 0; i < 3000; i++) begin
            req_valid  = ($urandom_range(0, 9) < 7);
            req_v0     = ($urandom_range(0, 19) < 17);
            req_src    = 2'($urandom_range(0, 3));
            req_way    = 8'($urandom);
            req_addr   = {3'b000, 3'($urandom_range(0, 7)), 6'($urandom)};
            wv         = ($urandom_range(0, 19) < 3);
            w_idx      = 6'($urandom_range(0, 7));
            w_way      = 8'($urandom);
            w_tag      = 20'($urandom);
            w_coh      = 2'($urandom);
            resp_ready = ($urandom_range(0, 9) < 6);
            cyc(1);
        end
        req_valid = 1'b0; wv = 1'b0; resp_ready = 1'b1;
        cyc(3);

        // Reset with two queued responses.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_way = 8'hFF; req_addr = 12'h140; req_v0 = 1'b1; req_src = 2'd0;
        cyc(2);
        req_valid = 1'b0;
        @(negedge clock); check("pre_rst_valid", 256'(resp_valid), 256'(1));
        check("pre_rst_full", 256'(req_ready), 256'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 256'(resp_valid), 256'(0));
        check("async_rst_done", 256'(init_done), 256'(0));
        cyc(3);
        reset = 1'b1;
        resp_ready = 1'b1;
        measure_init("init_len_rerun");
        @(negedge clock); check("no_stale", 256'(resp_valid), 256'(0));
        @(posedge clock); #1;
        do_req(8'hFF, 12'h140, 1'b1, 2'd1);
        expect_resp("cleared", 2'd1, 8'hFF, '0, '0);
        do_req(8'hFF, 12'h1C0, 1'b1, 2'd2);
        expect_resp("cleared7", 2'd2, 8'hFF, '0, '0);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
